register_file_mp: RTL and testbench

//  Parametrised multi-port integer register bank (x0..x{REG_COUNT-1}) for superscalar/OoO RISC-V cores.

---
 rtl/register_file_mp.sv | 173 +++++++++++++++++
 tb/tb_register_file_mp.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-port integer register bank (x0..x{REG_COUNT-1}) for superscalar and
//   out-of-order RISC-V cores. It provides asynchronous read ports, synchronous
//   write ports, optional write-to-read forwarding, a per-register busy
//   scoreboard for RAW hazard detection, and a sequential bank-clear FSM.
//   Register x0 always reads as zero and is never marked busy.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous reset, active low
//   i_rd_addr      read addresses, port p at [p*AW +: AW]
//   o_rd_data      read data, port p at [p*DW +: DW] (combinational)
//   o_rd_busy      per read port: addressed register has a pending producer
//   i_wr_en        per write port enable
//   i_wr_addr      write addresses, port w at [w*AW +: AW]
//   i_wr_data      write data, port w at [w*DW +: DW]
//   i_issue_valid  mark i_issue_addr busy (new producer issued)
//   i_issue_addr   destination register being issued
//   i_clear_req    start a bank clear (level, sampled only while idle)
//   o_clear_busy   clear FSM active (CLEAR or DONE)
//   o_clear_done   one-cycle pulse when a clear completes
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [NUM_RD*$clog2(REG_COUNT)-1:0]    i_rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]           o_rd_data,
  output logic [NUM_RD-1:0]                      o_rd_busy,
  input  logic [NUM_WR-1:0]                      i_wr_en,
  input  logic [NUM_WR*$clog2(REG_COUNT)-1:0]    i_wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]           i_wr_data,
  input  logic                                   i_issue_valid,
  input  logic [$clog2(REG_COUNT)-1:0]           i_issue_addr,
  input  logic                                   i_clear_req,
  output logic                                   o_clear_busy,
  output logic                                   o_clear_done
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(REG_COUNT);
  localparam logic [AW-1:0] LAST_IDX = AW'(REG_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [AW-1:0]     idx_q;
  logic              busy_q;
  logic              done_q;

  logic [DW-1:0]        regs_q [REG_COUNT];
  logic [DW-1:0]        regs_d [REG_COUNT];
  logic [REG_COUNT-1:0] sb_q;
  logic [REG_COUNT-1:0] sb_d;

  // Writes and issues are only honoured while the clear FSM is idle.
  logic accept;
  assign accept = (state_q == S_IDLE);

  // Clear FSM. idx walks 1..REG_COUNT-1 and stops there, so it never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_clear_req) begin
            state_q <= S_CLEAR;
            idx_q   <= AW'(1);
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_clear_busy = busy_q;
  assign o_clear_done = done_q;

  // Next state of the bank and scoreboard. Ports are applied in ascending
  // order so the highest-indexed port wins an address collision; the issue
  // is applied after the writes so a new producer keeps the register busy.
  always_comb begin
    regs_d = regs_q;
    sb_d   = sb_q;
    if (accept) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (i_wr_en[w] && (i_wr_addr[w*AW +: AW] != '0)) begin
          regs_d[i_wr_addr[w*AW +: AW]] = i_wr_data[w*DW +: DW];
          sb_d[i_wr_addr[w*AW +: AW]]   = 1'b0;
        end
      end
      if (i_issue_valid && (i_issue_addr != '0)) begin
        sb_d[i_issue_addr] = 1'b1;
      end
      // Starting a clear discards every pending producer.
      if (i_clear_req) begin
        sb_d = '0;
      end
    end else if (state_q == S_CLEAR) begin
      regs_d[idx_q] = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        regs_q[r] <= '0;
      end
      sb_q <= '0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        regs_q[r] <= regs_d[r];
      end
      sb_q <= sb_d;
    end
  end

  // Read ports: stored value, optionally overridden by a same-cycle write.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rdata;

    assign ra = i_rd_addr[p*AW +: AW];

    always_comb begin
      rdata = regs_q[ra];
      if ((BYPASS != 0) && accept) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (i_wr_en[w] && (i_wr_addr[w*AW +: AW] == ra)) begin
            rdata = i_wr_data[w*DW +: DW];
          end
        end
      end
      if (ra == '0) begin
        rdata = '0;
      end
    end

    assign o_rd_data[p*DW +: DW] = rdata;
    assign o_rd_busy[p]          = sb_q[ra];
  end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int RC = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data_b, rd_data_n;
  logic [NR-1:0]     busy_b, busy_n;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              issue_valid;
  logic [AW-1:0]     issue_addr;
  logic              clear_req;
  logic              cb_b, cd_b, cb_n, cd_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  register_file_mp #(.DATA_WIDTH(DW), .REG_COUNT(RC), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) u_byp (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b), .o_rd_busy(busy_b),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_issue_valid(issue_valid),
    .i_issue_addr(issue_addr), .i_clear_req(clear_req), .o_clear_busy(cb_b), .o_clear_done(cd_b)
  );

  register_file_mp #(.DATA_WIDTH(DW), .REG_COUNT(RC), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) u_nob (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data_n), .o_rd_busy(busy_n),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_issue_valid(issue_valid),
    .i_issue_addr(issue_addr), .i_clear_req(clear_req), .o_clear_busy(cb_n), .o_clear_done(cd_n)
  );

  // Reference model: architectural register contents, busy bits, and the
  // clear sequencer as a phase (0 idle, 1 clearing, 2 done) plus next index.
  logic [DW-1:0] m_reg [RC];
  bit            m_sb  [RC];
  int            m_phase;
  int            m_idx;

  task automatic model_reset();
    for (int r = 0; r < RC; r++) begin
      m_reg[r] = '0;
      m_sb[r]  = 1'b0;
    end
    m_phase = 0;
    m_idx   = 0;
  endtask

  task automatic model_edge();
    int a;
    if (m_phase == 0) begin
      for (int w = 0; w < NW; w++) begin
        a = int'(wr_addr[w*AW +: AW]);
        if (wr_en[w] && a != 0) begin
          m_reg[a] = wr_data[w*DW +: DW];
          m_sb[a]  = 1'b0;
        end
      end
      if (issue_valid && issue_addr != 0) m_sb[int'(issue_addr)] = 1'b1;
      if (clear_req) begin
        for (int r = 0; r < RC; r++) m_sb[r] = 1'b0;
        m_phase = 1;
        m_idx   = 1;
      end
    end else if (m_phase == 1) begin
      m_reg[m_idx] = '0;
      if (m_idx == RC - 1) m_phase = 2;
      else m_idx++;
    end else begin
      m_phase = 0;
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(int a, bit byp);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_reg[a];
    if (byp && m_phase == 0) begin
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) v = wr_data[w*DW +: DW];
      end
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reads(input string t);
    int a;
    for (int p = 0; p < NR; p++) begin
      a = int'(rd_addr[p*AW +: AW]);
      chk({t, "_rd_byp"}, rd_data_b[p*DW +: DW], exp_rd(a, 1'b1));
      chk({t, "_rd_nob"}, rd_data_n[p*DW +: DW], exp_rd(a, 1'b0));
      chk({t, "_busy_byp"}, {31'b0, busy_b[p]}, {31'b0, m_sb[a]});
      chk({t, "_busy_nob"}, {31'b0, busy_n[p]}, {31'b0, m_sb[a]});
    end
  endtask

  task automatic check_ctrl(input string t);
    chk({t, "_clr_busy"}, {31'b0, cb_b}, {31'b0, m_phase != 0});
    chk({t, "_clr_done"}, {31'b0, cd_b}, {31'b0, m_phase == 2});
    chk({t, "_clr_busy_nob"}, {31'b0, cb_n}, {31'b0, m_phase != 0});
    chk({t, "_clr_done_nob"}, {31'b0, cd_n}, {31'b0, m_phase == 2});
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step(input string t);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_ctrl(t);
  endtask

  task automatic idle_inputs();
    wr_en       = '0;
    issue_valid = 1'b0;
    clear_req   = 1'b0;
  endtask

  task automatic set_wr(input int w, input bit en, input int a, input logic [DW-1:0] d);
    wr_en[w]             = en;
    wr_addr[w*AW +: AW]  = AW'(a);
    wr_data[w*DW +: DW]  = d;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic sweep_zero(input string t);
    idle_inputs();
    for (int r = 0; r < RC; r += 2) begin
      set_rd(0, r);
      set_rd(1, r + 1);
      #1;
      chk({t, "_zero_a"}, rd_data_b[0 +: DW], 32'h0);
      chk({t, "_zero_b"}, rd_data_b[DW +: DW], 32'h0);
      chk({t, "_nobusy"}, {30'b0, busy_b}, 32'h0);
      step(t);
    end
  endtask

  int n_busy, n_done;

  initial begin
    // Reset state
    rst_n = 1'b0;
    idle_inputs();
    rd_addr = '0; wr_addr = '0; wr_data = '0; issue_addr = '0;
    model_reset();
    #12;
    check_ctrl("rst");
    set_rd(0, 9); set_rd(1, 31);
    #1;
    check_reads("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Two ports write x5 together: port 1 wins
    @(posedge clk); #1;
    set_wr(0, 1, 5, 32'h11); set_wr(1, 1, 5, 32'h22);
    set_rd(0, 5); set_rd(1, 0);
    #1;
    chk("t2_fwd_hi_port", rd_data_b[0 +: DW], 32'h22);
    chk("t2_nofwd_old", rd_data_n[0 +: DW], 32'h0);
    check_reads("t2a");
    step("t2a");
    idle_inputs();
    #1;
    chk("t2_x5_stored", rd_data_b[0 +: DW], 32'h22);
    chk("t2_x5_stored_nob", rd_data_n[0 +: DW], 32'h22);
    // Write to x0 is dropped, and never forwarded
    set_wr(0, 1, 0, 32'hFF); set_rd(0, 0);
    #1;
    chk("t2_x0_fwd", rd_data_b[0 +: DW], 32'h0);
    step("t2b");
    idle_inputs();
    #1;
    chk("t2_x0_after", rd_data_b[0 +: DW], 32'h0);

    // Same-cycle forwarding of x7
    set_wr(0, 1, 7, 32'hDEAD); set_rd(0, 7);
    #1;
    chk("t3_bypass", rd_data_b[0 +: DW], 32'hDEAD);
    chk("t3_no_bypass", rd_data_n[0 +: DW], 32'h0);
    step("t3");
    idle_inputs();

    // Scoreboard on x3
    issue_valid = 1'b1; issue_addr = 5'd3;
    set_rd(0, 3);
    #1;
    chk("t4_busy_not_yet", {31'b0, busy_b[0]}, 32'h0);
    step("t4a");
    idle_inputs();
    #1;
    chk("t4_busy_set", {31'b0, busy_b[0]}, 32'h1);
    set_wr(1, 1, 3, 32'h3333);
    #1;
    chk("t4_busy_same_cycle", {31'b0, busy_b[0]}, 32'h1);
    step("t4b");
    idle_inputs();
    #1;
    chk("t4_busy_cleared", {31'b0, busy_b[0]}, 32'h0);
    set_wr(0, 1, 3, 32'h4444); issue_valid = 1'b1; issue_addr = 5'd3;
    step("t4c");
    idle_inputs();
    #1;
    chk("t4_issue_wins", {31'b0, busy_b[0]}, 32'h1);
    chk("t4_data", rd_data_b[0 +: DW], 32'h4444);
    check_reads("t4");

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int w = 0; w < NW; w++) begin
        set_wr(w, $urandom_range(0, 1) == 1,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, RC - 1)),
               $urandom);
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_addr  = AW'($urandom_range(0, RC - 1));
      clear_req   = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NR; p++) begin
        if ($urandom_range(0, 1) == 1) set_rd(p, int'(wr_addr[($urandom_range(0, NW - 1))*AW +: AW]));
        else set_rd(p, int'($urandom_range(0, RC - 1)));
      end
      #1;
      check_reads("rnd");
      step("rnd");
    end
    idle_inputs();
    for (int c = 0; c < 40; c++) step("drain");

    // Bank clear after filling every register
    for (int r = 1; r < RC; r++) begin
      set_wr(0, 1, r, 32'hA5A5A5A5);
      step("fill");
    end
    idle_inputs();
    clear_req = 1'b1;
    n_busy = 0; n_done = 0;
    step("clr_start");
    if (cb_b) n_busy++;
    if (cd_b) n_done++;
    clear_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (m_phase != 0) begin
        for (int w = 0; w < NW; w++) set_wr(w, 1'b1, int'($urandom_range(1, RC - 1)), $urandom);
        issue_valid = 1'b1;
        issue_addr  = AW'($urandom_range(1, RC - 1));
      end else begin
        idle_inputs();
      end
      set_rd(0, int'($urandom_range(0, RC - 1)));
      set_rd(1, int'(wr_addr[AW +: AW]));
      #1;
      check_reads("clr");
      step("clr");
      if (cb_b) n_busy++;
      if (cd_b) n_done++;
    end
    chk("t5_busy_cycles", n_busy, 32);
    chk("t5_done_pulses", n_done, 1);
    sweep_zero("t5");

    // Reset in the middle of a clear
    for (int r = 1; r < RC; r++) begin
      set_wr(0, 1, r, $urandom);
      issue_valid = 1'b1; issue_addr = AW'(RC - r);
      step("fill2");
    end
    idle_inputs();
    clear_req = 1'b1;
    step("clr2_start");
    clear_req = 1'b0;
    for (int c = 0; c < 9; c++) step("clr2");
    rst_n = 1'b0;
    model_reset();
    #1;
    check_ctrl("t6_rst");
    set_rd(0, 20); set_rd(1, 31);
    #1;
    check_reads("t6_rst");
    n_done = 0;
    for (int c = 0; c < 3; c++) begin
      step("t6_hold");
      if (cd_b) n_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step("t6_post");
      if (cd_b) n_done++;
    end
    chk("t6_no_done", n_done, 0);
    sweep_zero("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
